// File: rtl/counter_mon_pkg.sv
// rtl/counter_mon_pkg.sv - shared types and constants for the counter wrap monitor
package counter_mon_pkg;

    typedef enum logic [1:0] {
        EVT_NONE = 2'b00,
        EVT_WRAP = 2'b01,
        EVT_OVF  = 2'b10,
        EVT_BOTH = 2'b11
    } evt_type_e;

    localparam logic [7:0] SAT_MAX = 8'hFF;

    // Record layout is {type[1:0], timestamp[ts_w-1:0]}
    function automatic int rec_width(input int ts_w);
        return ts_w + 2;
    endfunction

endpackage

// File: rtl/counter_wrap_monitor_if.sv
// rtl/counter_wrap_monitor_if.sv - valid/ready event record stream
interface counter_wrap_monitor_if #(
    parameter int TS_W = 8
) ();
    localparam int REC_W = counter_mon_pkg::rec_width(TS_W);

    logic             evt_valid;
    logic             evt_ready;
    logic [REC_W-1:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/counter_wrap_monitor_evt_fifo.sv
// rtl/counter_wrap_monitor_evt_fifo.sv - synchronous FIFO holding event records
module evt_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic          pop_ok, push_ok;

    assign empty  = (level_q == '0);
    assign full   = (level_q == (AW+1)'(DEPTH));
    assign level  = level_q;
    assign pop_ok = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok   = push && (!full || pop_ok);
    assign head_data = empty ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        level_d = level_q;
        if (clear) begin
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + 1'b1;
            if (pop_ok)  rd_d = rd_q + 1'b1;
            level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/counter_wrap_monitor.sv
// rtl/counter_wrap_monitor.sv - wrap/overflow edge detector with timestamped event FIFO
module counter_wrap_monitor
    import counter_mon_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [CNT_W-1:0]            cnt_in,
    input  logic                        ovf_in,
    input  logic                        clear,
    counter_wrap_monitor_if.master      evt,
    output logic [7:0]                  wrap_count,
    output logic [7:0]                  drop_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int REC_W = rec_width(TS_W);

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] prev_cnt_q;
    logic             prev_ovf_q, prev_valid_q, prev_valid_d;
    logic [7:0]       wrap_q, wrap_d, drop_q, drop_d;

    logic             wrap_det, ovf_det, push, pop, fifo_full, fifo_empty;
    evt_type_e        evt_type;
    logic [REC_W-1:0] rec;

    assign wrap_det = prev_valid_q && (prev_cnt_q == '1) && (cnt_in == '0);
    assign ovf_det  = prev_valid_q && !prev_ovf_q && ovf_in;
    assign evt_type = evt_type_e'({ovf_det, wrap_det});
    assign rec      = {evt_type, ts_q};

    // Clear overrides everything in its cycle, so it also gates the FIFO strobes
    assign push = (wrap_det || ovf_det) && !clear;
    assign pop  = evt.evt_valid && evt.evt_ready && !clear;

    always_comb begin
        ts_d         = ts_q + 1'b1;
        prev_valid_d = 1'b1;
        wrap_d       = wrap_q;
        drop_d       = drop_q;
        if (clear) begin
            ts_d         = '0;
            prev_valid_d = 1'b0;
            wrap_d       = '0;
            drop_d       = '0;
        end else begin
            if (wrap_det && wrap_q != SAT_MAX) wrap_d = wrap_q + 8'd1;
            if (push && fifo_full && !pop && drop_q != SAT_MAX) drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_q         <= '0;
            prev_cnt_q   <= '0;
            prev_ovf_q   <= 1'b0;
            prev_valid_q <= 1'b0;
            wrap_q       <= '0;
            drop_q       <= '0;
        end else begin
            ts_q         <= ts_d;
            prev_cnt_q   <= cnt_in;
            prev_ovf_q   <= ovf_in;
            prev_valid_q <= prev_valid_d;
            wrap_q       <= wrap_d;
            drop_q       <= drop_d;
        end
    end

    evt_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push),
        .push_data (rec),
        .pop       (pop),
        .head_data (evt.evt_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign evt.evt_valid = !fifo_empty;
    assign wrap_count    = wrap_q;
    assign drop_count    = drop_q;

endmodule

// File: doc/counter_wrap_monitor.md
# counter_wrap_monitor

Downstream observer for the 4-bit up-counter stage. Samples the counter value and overflow flag every clock and detects wrap-around (all-ones to zero) and overflow rising edges. Each event becomes a timestamped record in a small FIFO, drained through a valid/ready interface, with saturating wrap and drop statistics exposed alongside.

## Interface
- CNT_W, 4: width of the monitored counter value
- TS_W, 8: width of the free-running timestamp
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cnt_in  in  CNT_W  counter value from the counter stage
- ovf_in  in  1  overflow flag from the counter stage
- clear  in  1  synchronous clear of all state, active high
- evt_valid  out  1  a record is available at the FIFO head
- evt_ready  in  1  consumer accepts the head record
- evt_data  out  2+TS_W  record: bits [TS_W+1:TS_W] = type, bits [TS_W-1:0] = timestamp
- wrap_count  out  8  number of wraps seen, saturating
- drop_count  out  8  records lost to a full FIFO, saturating
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Reset (reset_n low, asynchronous): all outputs 0. The FIFO is empty, the timestamp is 0, prev_valid is 0, the prev_cnt and prev_ovf registers are 0.
- Timestamp: TS_W-bit counter, increments every cycle, wraps from all-ones to 0 with no side effect.
- At every edge the block registers prev_cnt <= cnt_in and prev_ovf <= ovf_in, and sets prev_valid <= 1.
- Wrap detect: prev_valid && prev_cnt == all-ones && cnt_in == 0. Other jumps, such as 1111 to 0011 or a hold at 1111, are not wraps.
- Overflow detect: prev_valid && !prev_ovf && ovf_in. A level that is held produces no further events. Falling edges are ignored.
- Record types: 2'b01 = wrap only, 2'b10 = overflow rise only, 2'b11 = both in the same cycle (one record, not two). Type 2'b00 is never emitted.
- Push: a record is generated in any cycle where a detect fires. Its timestamp is the timestamp value before that edge's increment.
- The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
- If the push is not accepted, drop_count increments, saturating at 255. The record is discarded.
- wrap_count increments on every wrap detect, including wraps whose record is dropped, and saturates at 255.
- Pop: when evt_valid && evt_ready, the head is removed at the edge.
- evt_valid = (fifo_level != 0). evt_data holds the head and stays stable while evt_valid is high and evt_ready is low.
- clear: same effect as reset, but synchronous. It has priority over detects, pushes and pops in that cycle. The cnt_in and ovf_in values present during clear are still captured into prev_cnt and prev_ovf, but prev_valid is forced to 0, so the first edge after clear cannot fire a detect.

## Timing
- All state is updated on the rising edge of clk. There are no combinational paths from inputs to outputs, except evt_valid and evt_data depending on registered FIFO state only.
- Event latency: a detect evaluated at edge k is written at edge k. evt_valid and the new fifo_level are visible in the cycle after edge k, giving one cycle from input to record.
- Pop latency: when evt_ready is sampled high at edge k, the next head (or evt_valid low) is visible after edge k.
- Full FIFO with simultaneous push and pop: both happen, fifo_level is unchanged, and drop_count is unchanged.
- Empty FIFO with simultaneous push and evt_ready high: there is no bypass. The record appears the next cycle.
- Reset asserted mid-operation: state clears immediately and asynchronously. On release, the first sampling edge only loads prev_cnt and prev_ovf.

## Structure
- Package counter_mon_pkg holds:
  - the evt_type enum: EVT_NONE = 2'b00, EVT_WRAP = 2'b01, EVT_OVF = 2'b10, EVT_BOTH = 2'b11
  - the record-width function of TS_W
  - the saturating-count limit constant (8'hFF)
- Sub-module evt_fifo is a synchronous FIFO, parameterised on width and depth. It has push, pop, full, empty, level and clear, uses the same asynchronous active-low reset, and implements the full-with-pop acceptance rule internally.
- The top level contains detection, the timestamp, the statistics counters and the evt_fifo instance.

## Test plan
- Release reset with cnt_in = 0000, then count 0 to 15 and back to 0, with evt_ready = 1. Expect exactly one record of type 01, with timestamp equal to the cycle index of the 1111 to 0000 edge, and wrap_count = 1.
- Hold ovf_in high for 5 cycles, pulse it low for one cycle, then high again. Expect exactly 2 records of type 10 and no falling-edge records.
- Apply the 1111 to 0000 step and the ovf_in 0 to 1 step in the same cycle. Expect one record of type 11 and wrap_count + 1.
- With evt_ready = 0, generate 6 wraps. Expect fifo_level = 4 and drop_count = 2, with records 1 to 4 in order. Then set evt_ready = 1 and expect them drained oldest-first.
- With the FIFO full, generate a wrap while evt_ready = 1. Expect fifo_level to stay 4, drop_count unchanged, and the new record at the tail.
- Assert clear with 3 records queued and an event firing in the same cycle. Expect fifo_level = 0, all counts 0 and timestamp 0. A 1111 to 0000 step on the first edge after clear must produce no record.
